bp_fe_cache_req_arbiter: RTL and testbench

Shares the single front-end LCE cache-service port between two fetch-side requesters: the I-cache demand miss path (port 0) and the uncached/prefetch fetch engine (port 1). It sits between the fetch memory stage and the LCE. It arbitrates round-robin, with optional demand priority, and grants one request at a time. It then locks the port to the winner until the LCE signals completion, routing metadata and completion accordingly.

---
 rtl/bp_fe_pkg.sv | 10 +
 rtl/bsg_arb_round_robin.sv | 12 +
 rtl/bp_fe_cache_req_arbiter.sv | 111 +++++++++++
 tb/tb_bp_fe_cache_req_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Front-end shared types: state encoding for the cache-request arbiter FSM.
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_meta  = 2'd1,
        e_busy  = 2'd2
    } bp_fe_cache_req_arb_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Two-input round-robin arbiter; the caller keeps the last-owner pointer.
module bsg_arb_round_robin (
    input  logic [1:0] reqs_i,
    input  logic       last_i,
    output logic [1:0] grants_o
);

    // On a tie the port after last_i wins; a lone request always wins.
    assign grants_o[0] = reqs_i[0] & (~reqs_i[1] | last_i);
    assign grants_o[1] = reqs_i[1] & (~reqs_i[0] | ~last_i);

endmodule

// File: rtl/bp_fe_cache_req_arbiter.sv
// Shares the front-end LCE cache-service port between the I-cache miss path (port 0)
// and the fetch engine (port 1); the winner owns the port until the LCE completes.
module bp_fe_cache_req_arbiter
    import bp_fe_pkg::*;
#(
    parameter int cache_req_width_p          = 8,
    parameter int cache_req_metadata_width_p = 4,
    parameter bit demand_priority_p          = 1'b0
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [2*cache_req_width_p-1:0]          req_i,
    input  logic [1:0]                              req_v_i,
    output logic [1:0]                              req_ready_o,
    input  logic [2*cache_req_metadata_width_p-1:0] req_metadata_i,
    input  logic [1:0]                              req_metadata_v_i,
    output logic [1:0]                              req_complete_o,
    output logic [cache_req_width_p-1:0]            cache_req_o,
    output logic                                    cache_req_v_o,
    input  logic                                    cache_req_ready_i,
    output logic [cache_req_metadata_width_p-1:0]   cache_req_metadata_o,
    output logic                                    cache_req_metadata_v_o,
    input  logic                                    cache_req_complete_i
);

    bp_fe_cache_req_arb_state_e state_q, state_d;
    logic owner_q, owner_d;
    logic last_owner_q, last_owner_d;
    logic [1:0] grant;
    logic [1:0] accept;
    logic       accept_idx;

    generate
        if (demand_priority_p) begin : g_prio
            assign grant[0] = req_v_i[0];
            assign grant[1] = req_v_i[1] & ~req_v_i[0];
        end else begin : g_rr
            bsg_arb_round_robin u_rr (
                .reqs_i   (req_v_i),
                .last_i   (last_owner_q),
                .grants_o (grant)
            );
        end
    endgenerate

    assign accept     = req_v_i & req_ready_o;
    assign accept_idx = accept[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= e_ready;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        owner_d                = owner_q;
        last_owner_d           = last_owner_q;
        req_ready_o            = 2'b00;
        req_complete_o         = 2'b00;
        cache_req_v_o          = 1'b0;
        cache_req_metadata_v_o = 1'b0;
        cache_req_o            = req_i[accept_idx*cache_req_width_p +: cache_req_width_p];
        cache_req_metadata_o   = req_metadata_i[owner_q*cache_req_metadata_width_p +: cache_req_metadata_width_p];

        case (state_q)
            e_ready: begin
                req_ready_o   = {2{cache_req_ready_i}} & grant;
                cache_req_v_o = |accept;
                if (|accept) begin
                    owner_d = accept_idx;
                    state_d = e_meta;
                end
            end
            e_meta: begin
                cache_req_metadata_v_o         = req_metadata_v_i[owner_q];
                req_complete_o[owner_q]        = cache_req_complete_i;
                // Completion without metadata still ends the transaction.
                if (cache_req_complete_i) begin
                    last_owner_d = owner_q;
                    state_d      = e_ready;
                end else if (req_metadata_v_i[owner_q]) begin
                    state_d = e_busy;
                end
            end
            e_busy: begin
                req_complete_o[owner_q] = cache_req_complete_i;
                if (cache_req_complete_i) begin
                    last_owner_d = owner_q;
                    state_d      = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase

        // Registered state may still be mid-transaction during the reset cycle.
        if (reset_i) begin
            req_ready_o            = 2'b00;
            req_complete_o         = 2'b00;
            cache_req_v_o          = 1'b0;
            cache_req_metadata_v_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Directed bench: round-robin instance (dut0) and demand-priority instance (dut1).
module tb_bp_fe_cache_req_arbiter;

    localparam int W = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] ri0, ri1;
    logic [1:0]     rv0, rv1, rmv0, rmv1;
    logic [2*M-1:0] rm0, rm1;
    logic           crr0, crr1, cc0, cc1;
    logic [1:0]     rdy0, rdy1, cpl0, cpl1;
    logic [W-1:0]   cro0, cro1;
    logic           crv0, crv1, cmv0, cmv1;
    logic [M-1:0]   cmo0, cmo1;

    bp_fe_cache_req_arbiter #(.cache_req_width_p(W), .cache_req_metadata_width_p(M), .demand_priority_p(1'b0)) dut0 (
        .clk_i(clk), .reset_i(reset), .req_i(ri0), .req_v_i(rv0), .req_ready_o(rdy0),
        .req_metadata_i(rm0), .req_metadata_v_i(rmv0), .req_complete_o(cpl0),
        .cache_req_o(cro0), .cache_req_v_o(crv0), .cache_req_ready_i(crr0),
        .cache_req_metadata_o(cmo0), .cache_req_metadata_v_o(cmv0), .cache_req_complete_i(cc0));

    bp_fe_cache_req_arbiter #(.cache_req_width_p(W), .cache_req_metadata_width_p(M), .demand_priority_p(1'b1)) dut1 (
        .clk_i(clk), .reset_i(reset), .req_i(ri1), .req_v_i(rv1), .req_ready_o(rdy1),
        .req_metadata_i(rm1), .req_metadata_v_i(rmv1), .req_complete_o(cpl1),
        .cache_req_o(cro1), .cache_req_v_o(crv1), .cache_req_ready_i(crr1),
        .cache_req_metadata_o(cmo1), .cache_req_metadata_v_o(cmv1), .cache_req_complete_i(cc1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ri0 = {8'hB1, 8'hA0}; rm0 = {4'hC, 4'h3};
        ri1 = {8'h5E, 8'h4D}; rm1 = {4'h9, 4'h6};
        // Drive everything active during reset to prove outputs are forced low.
        reset = 1'b1; rv0 = 2'b11; rmv0 = 2'b11; crr0 = 1'b1; cc0 = 1'b1;
        rv1 = 2'b11; rmv1 = 2'b11; crr1 = 1'b1; cc1 = 1'b1;
        next_cycle(); next_cycle();
        sample();
        chk("rst_ready0", rdy0, 2'b00);
        chk("rst_v0", crv0, 1'b0);
        chk("rst_mv0", cmv0, 1'b0);
        chk("rst_cpl0", cpl0, 2'b00);
        chk("rst_ready1", rdy1, 2'b00);
        next_cycle();
        reset = 1'b0; rv0 = 2'b00; rmv0 = 2'b00; cc0 = 1'b0;
        rv1 = 2'b00; rmv1 = 2'b00; cc1 = 1'b0;

        // Single demand miss on port 0: accept, metadata, complete three cycles later.
        next_cycle(); rv0 = 2'b01;
        sample();
        chk("dm_ready", rdy0, 2'b01);
        chk("dm_v", crv0, 1'b1);
        chk("dm_req", cro0, 8'hA0);
        next_cycle(); rv0 = 2'b00; rmv0 = 2'b01;
        sample();
        chk("dm_meta_v", cmv0, 1'b1);
        chk("dm_meta", cmo0, 4'h3);
        chk("dm_meta_ready", rdy0, 2'b00);
        chk("dm_meta_reqv", crv0, 1'b0);
        next_cycle(); rmv0 = 2'b00;
        sample(); chk("dm_busy_c2", cpl0, 2'b00);
        next_cycle();
        sample(); chk("dm_busy_c3", rdy0, 2'b00);
        next_cycle(); cc0 = 1'b1;
        sample(); chk("dm_complete", cpl0, 2'b01);
        // Ready again the next cycle: a lone port-1 request is accepted.
        next_cycle(); cc0 = 1'b0; rv0 = 2'b10;
        sample();
        chk("dm_ready_again", rdy0, 2'b10);
        chk("p1_req", cro0, 8'hB1);

        // Completion in e_meta (no metadata), then a stray completion in e_ready.
        next_cycle(); rv0 = 2'b00; cc0 = 1'b1;
        sample(); chk("nometa_cpl", cpl0, 2'b10);
        next_cycle();
        sample();
        chk("stray_cpl", cpl0, 2'b00);
        chk("stray_v", crv0, 1'b0);

        // Round robin with both valids held: expected order 0,1,0,1 (last owner is 1).
        for (int t = 0; t < 4; t++) begin
            logic [1:0] exp_g;
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            next_cycle(); cc0 = 1'b0; rv0 = 2'b11; rmv0 = 2'b00;
            sample();
            chk($sformatf("rr_ready_%0d", t), rdy0, exp_g);
            chk($sformatf("rr_req_%0d", t), cro0, (t % 2 == 0) ? 8'hA0 : 8'hB1);
            // Only the non-owner's metadata is valid: it must be ignored.
            next_cycle(); rmv0 = ~exp_g;
            sample();
            chk($sformatf("rr_nonowner_mv_%0d", t), cmv0, 1'b0);
            chk($sformatf("rr_meta_ready_%0d", t), rdy0, 2'b00);
            next_cycle(); rmv0 = 2'b11;
            sample();
            chk($sformatf("rr_meta_%0d", t), cmo0, (t % 2 == 0) ? 4'h3 : 4'hC);
            next_cycle(); rmv0 = 2'b00; cc0 = 1'b1;
            sample();
            chk($sformatf("rr_cpl_%0d", t), cpl0, exp_g);
        end

        // LCE backpressure: port 1 waits five cycles, accepted when ready rises.
        next_cycle(); cc0 = 1'b0; rv0 = 2'b10; crr0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk($sformatf("bp_ready_%0d", c), rdy0, 2'b00);
            chk($sformatf("bp_v_%0d", c), crv0, 1'b0);
            next_cycle();
        end
        crr0 = 1'b1;
        sample();
        chk("bp_accept_ready", rdy0, 2'b10);
        chk("bp_accept_v", crv0, 1'b1);
        chk("bp_accept_req", cro0, 8'hB1);
        next_cycle(); rv0 = 2'b00; rmv0 = 2'b10;
        sample(); chk("bp_meta", cmo0, 4'hC);
        next_cycle(); rmv0 = 2'b00;

        // Reset while port 1 owns the port in e_busy.
        next_cycle(); reset = 1'b1; rv0 = 2'b11; cc0 = 1'b1; rmv0 = 2'b11;
        sample();
        chk("mid_rst_ready", rdy0, 2'b00);
        chk("mid_rst_cpl", cpl0, 2'b00);
        chk("mid_rst_v", crv0, 1'b0);
        chk("mid_rst_mv", cmv0, 1'b0);
        next_cycle(); reset = 1'b0; cc0 = 1'b0; rmv0 = 2'b00;
        sample();
        chk("post_rst_tie", rdy0, 2'b01);
        chk("post_rst_req", cro0, 8'hA0);
        next_cycle(); rv0 = 2'b00; cc0 = 1'b1;
        sample(); chk("post_rst_cpl", cpl0, 2'b01);
        next_cycle(); cc0 = 1'b0;

        // Demand priority instance: port 0 wins every tie.
        for (int t = 0; t < 3; t++) begin
            next_cycle(); rv1 = 2'b11; cc1 = 1'b0;
            sample();
            chk($sformatf("pr_ready_%0d", t), rdy1, 2'b01);
            chk($sformatf("pr_req_%0d", t), cro1, 8'h4D);
            next_cycle(); rmv1 = 2'b01;
            sample();
            chk($sformatf("pr_meta_%0d", t), cmo1, 4'h6);
            chk($sformatf("pr_meta_ready_%0d", t), rdy1, 2'b00);
            next_cycle(); rmv1 = 2'b00; cc1 = 1'b1;
            sample();
            chk($sformatf("pr_cpl_%0d", t), cpl1, 2'b01);
        end
        next_cycle(); cc1 = 1'b0; rv1 = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
